// File: rtl/shifter8_right_seq_if.sv
// Handshake and data bundle between a controller and the sequential
// 8-bit right shifter.
interface shifter8_right_seq_if;
    logic       start;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic       arith;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    modport master (
        output start, d_in, shamt, arith,
        input  d_out, busy, done
    );

    modport slave (
        input  start, d_in, shamt, arith,
        output d_out, busy, done
    );
endinterface

// File: rtl/shifter8_right_seq.sv
// Sequential 8-bit right shifter: loads an operand on start and shifts it
// right by 0-7 bits, at most 3 positions per clock, with logical or arithmetic fill.
module shifter8_right_seq (
    input  logic                  clk,
    input  logic                  reset_n,
    shifter8_right_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r;
    logic [7:0] data_r;
    logic [2:0] rem_r;
    logic       arith_r;
    logic       sign_r;
    logic       busy_r;
    logic       done_r;

    logic [1:0] step_s;
    logic [2:0] rem_next_s;
    logic [7:0] shifted_s;
    logic       fill_s;

    // One 4-way step: sel 0 passes through, sel 1/2/3 take bit i+sel or the fill bit.
    function automatic logic [7:0] shift_step(
        input logic [7:0] d,
        input logic [1:0] sel,
        input logic       fill
    );
        logic [10:0] ext;
        logic [7:0]  res;
        ext = {fill, fill, fill, d};
        case (sel)
            2'd0:    res = ext[7:0];
            2'd1:    res = ext[8:1];
            2'd2:    res = ext[9:2];
            2'd3:    res = ext[10:3];
            default: res = d;
        endcase
        return res;
    endfunction

    // Step size, next remaining count and shifted value for the SHIFT state.
    always_comb begin
        step_s     = 2'd0;
        rem_next_s = 3'd0;
        shifted_s  = 8'h00;
        fill_s     = arith_r & sign_r;
        if (rem_r > 3'd3) begin
            step_s = 2'd3;
        end else begin
            step_s = rem_r[1:0];
        end
        rem_next_s = rem_r - {1'b0, step_s};
        shifted_s  = shift_step(data_r, step_s, fill_s);
    end

    // Control FSM with working register; done is issued the cycle after DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            data_r  <= 8'h00;
            rem_r   <= 3'd0;
            arith_r <= 1'b0;
            sign_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        data_r  <= bus.d_in;
                        rem_r   <= bus.shamt;
                        arith_r <= bus.arith;
                        sign_r  <= bus.d_in[7];
                        busy_r  <= 1'b1;
                        if (bus.shamt != 3'd0) begin
                            state_r <= SHIFT;
                        end else begin
                            state_r <= DONE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    data_r <= shifted_s;
                    rem_r  <= rem_next_s;
                    busy_r <= 1'b1;
                    if (rem_next_s == 3'd0) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_out = data_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_shifter8_right_seq.sv
// Directed and exhaustive self-checking bench for shifter8_right_seq.
module tb_shifter8_right_seq;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    shifter8_right_seq_if bus ();

    shifter8_right_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge (edge 0).
    task automatic start_op(input logic [7:0] d, input logic [2:0] s, input logic a);
        bus.start = 1'b1;
        bus.d_in  = d;
        bus.shamt = s;
        bus.arith = a;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starting in the cycle after edge 0, returns in the done cycle with its edge index.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k <= 8; k++) begin
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] s);
        if (s == 3'd0)      return 1;
        else if (s <= 3'd3) return 2;
        else if (s <= 3'd6) return 3;
        else                return 4;
    endfunction

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s, input logic a);
        logic signed [7:0] sd;
        sd = d;
        if (a) return sd >>> s;
        else   return d >> s;
    endfunction

    initial begin
        int lat;
        int seen_done;
        logic [7:0] exp_v;
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        bus.start = 1'b1;
        bus.d_in  = 8'hAA;
        bus.shamt = 3'd3;
        bus.arith = 1'b0;

        // Reset held two edges with start asserted
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_dout", {24'd0, bus.d_out}, 32'h00);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("rst_nostart", {31'd0, bus.busy}, 32'd0);

        // LSR 0xB6 >> 3
        start_op(8'hB6, 3'd3, 1'b0);
        chk("lsr3_busy", {31'd0, bus.busy}, 32'd1);
        chk("lsr3_load", {24'd0, bus.d_out}, 32'hB6);
        wait_done(lat);
        chk("lsr3_lat", lat, 32'd2);
        chk("lsr3_val", {24'd0, bus.d_out}, 32'h16);
        chk("lsr3_busy_low", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("lsr3_pulse", {31'd0, bus.done}, 32'd0);

        // ASR 0xB6 >>> 3
        start_op(8'hB6, 3'd3, 1'b1);
        wait_done(lat);
        chk("asr3_lat", lat, 32'd2);
        chk("asr3_val", {24'd0, bus.d_out}, 32'hF6);
        @(negedge clk);

        // ASR 0xB6 >>> 7 with intermediate values
        start_op(8'hB6, 3'd7, 1'b1);
        @(negedge clk);
        chk("asr7_e1", {24'd0, bus.d_out}, 32'hF6);
        @(negedge clk);
        chk("asr7_e2", {24'd0, bus.d_out}, 32'hFE);
        @(negedge clk);
        chk("asr7_e3", {24'd0, bus.d_out}, 32'hFF);
        chk("asr7_e3_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        chk("asr7_e4_done", {31'd0, bus.done}, 32'd1);
        chk("asr7_val", {24'd0, bus.d_out}, 32'hFF);
        @(negedge clk);

        // LSR 0xB6 >> 7
        start_op(8'hB6, 3'd7, 1'b0);
        wait_done(lat);
        chk("lsr7_lat", lat, 32'd4);
        chk("lsr7_val", {24'd0, bus.d_out}, 32'h01);
        @(negedge clk);

        // shamt 0 then back-to-back start in the done cycle
        start_op(8'h81, 3'd0, 1'b1);
        wait_done(lat);
        chk("sh0_lat", lat, 32'd1);
        chk("sh0_val", {24'd0, bus.d_out}, 32'h81);
        start_op(8'h40, 3'd5, 1'b0);
        wait_done(lat);
        chk("b2b_lat", lat, 32'd3);
        chk("b2b_val", {24'd0, bus.d_out}, 32'h02);
        @(negedge clk);

        // start and operand changes during SHIFT are ignored
        start_op(8'hB6, 3'd5, 1'b0);
        bus.start = 1'b1;
        bus.d_in  = 8'hFF;
        bus.shamt = 3'd7;
        bus.arith = 1'b1;
        wait_done(lat);
        bus.start = 1'b0;
        chk("intf_lat", lat, 32'd3);
        chk("intf_val", {24'd0, bus.d_out}, 32'h05);
        @(negedge clk);
        chk("intf_idle", {31'd0, bus.busy}, 32'd0);

        // Reset during SHIFT abandons the operation
        start_op(8'hB6, 3'd7, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_shift_dout", {24'd0, bus.d_out}, 32'h00);
        chk("rst_shift_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_shift_done", {31'd0, bus.done}, 32'd0);
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done++;
        end
        chk("rst_shift_nodone", seen_done, 32'd0);

        // Exhaustive sweep against reference >> / >>>
        for (int a = 0; a < 2; a++) begin
            for (int s = 0; s < 8; s++) begin
                for (int d = 0; d < 256; d++) begin
                    exp_v = ref_shift(d[7:0], s[2:0], a[0]);
                    start_op(d[7:0], s[2:0], a[0]);
                    wait_done(lat);
                    chk("sweep_val", {24'd0, bus.d_out}, {24'd0, exp_v});
                    chk("sweep_lat", lat, exp_lat(s[2:0]));
                    @(negedge clk);
                    chk("sweep_pulse", {31'd0, bus.done}, 32'd0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
